// File: rtl/find_majority_stream.sv
// Streaming strict-majority finder: buffers up to MAX_N words, runs a Boyer-Moore
// vote pass and a verify pass, then reports the majority element or NO_MAJ.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for ap_start; latches clipped length
// S_LOAD   | accepting stream words into the buffer (in_ready high)
// S_VOTE   | Boyer-Moore candidate pass, one element per cycle
// S_VERIFY | counts occurrences of the candidate, one element per cycle
// S_DONE   | one-cycle ap_done/ap_ready pulse with result valid
module find_majority_stream #(
    parameter int DATA_W = 32,
    parameter int MAX_N  = 64,
    parameter int CNT_W  = $clog2(MAX_N + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [CNT_W-1:0]  n_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] ap_return,
    output logic              found
);

    localparam int                AW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(MAX_N);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [DATA_W-1:0] NO_MAJ  = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VOTE, S_VERIFY, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [DATA_W-1:0] r_buf [MAX_N];
    logic [CNT_W-1:0]  r_len, r_idx, r_cnt, r_hits;
    logic [DATA_W-1:0] r_cand, r_ret;
    logic              r_found;

    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_elem;
    logic              w_last, w_match, w_found_nxt, w_load_fire;
    logic [CNT_W-1:0]  w_len_clip, w_hits_nxt;

    // idx never exceeds len-1 < MAX_N while addressing the buffer
    assign w_addr      = r_idx[AW-1:0];
    assign w_elem      = r_buf[w_addr];
    assign w_last      = (r_idx == r_len - ONE);
    assign w_match     = (w_elem == r_cand);
    assign w_len_clip  = (n_len > MAX_LEN) ? MAX_LEN : n_len;
    assign w_hits_nxt  = r_hits + CNT_W'(w_match);
    assign w_found_nxt = ({w_hits_nxt, 1'b0} > {1'b0, r_len});
    assign w_load_fire = (r_state == S_LOAD) && in_valid;

    assign ap_return = r_ret;
    assign found     = r_found;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = (w_len_clip == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_last) w_state_nxt = S_VOTE;
            end
            S_VOTE:   if (w_last) w_state_nxt = S_VERIFY;
            S_VERIFY: if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                ap_done     = 1'b1;
                ap_ready    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (w_load_fire) r_buf[w_addr] <= in_data;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_len   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_hits  <= '0;
            r_cand  <= '0;
            r_ret   <= NO_MAJ;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_len <= w_len_clip;
                        r_idx <= '0;
                        if (w_len_clip == '0) begin
                            r_ret   <= NO_MAJ;
                            r_found <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (w_last) begin
                            r_idx  <= '0;
                            r_cand <= '0;
                            r_cnt  <= '0;
                        end else begin
                            r_idx <= r_idx + ONE;
                        end
                    end
                end
                S_VOTE: begin
                    if (r_cnt == '0) begin
                        r_cand <= w_elem;
                        r_cnt  <= ONE;
                    end else if (w_match) begin
                        r_cnt <= r_cnt + ONE;
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                    if (w_last) begin
                        r_idx  <= '0;
                        r_hits <= '0;
                    end else begin
                        r_idx <= r_idx + ONE;
                    end
                end
                S_VERIFY: begin
                    r_hits <= w_hits_nxt;
                    r_idx  <= r_idx + ONE;
                    // result registers update as DONE is entered so they are valid with ap_done
                    if (w_last) begin
                        r_found <= w_found_nxt;
                        r_ret   <= w_found_nxt ? r_cand : NO_MAJ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_find_majority_stream.sv
// Directed table-driven bench for find_majority_stream (DATA_W=32, MAX_N=64).
module tb_find_majority_stream;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start, in_valid;
    logic        ap_done, ap_idle, ap_ready, in_ready, found;
    logic [6:0]  n_len;
    logic [31:0] in_data, ap_return;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] NM   = 32'hFFFF_FFFF;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic [6:0]       n_len;
        logic [7:0]       pat;     // in_valid pattern over LOAD cycles, bit k%8 for cycle k
        logic [7:0][31:0] words;   // element i taken from words[i%8]
        logic [31:0]      exp_ret;
        logic             exp_found;
    } vec_t;

    vec_t vecs[10];
    vec_t v_after_rst;
    int   bad;

    find_majority_stream dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .n_len    (n_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ap_return(ap_return),
        .found    (found)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [6:0] len, input logic [7:0] pat,
                                input logic [31:0] a, b, c, d, e, f, g, h,
                                input logic [31:0] er, input logic ef);
        vec_t v;
        v.n_len = len;
        v.pat   = pat;
        v.words[0] = a; v.words[1] = b; v.words[2] = c; v.words[3] = d;
        v.words[4] = e; v.words[5] = f; v.words[6] = g; v.words[7] = h;
        v.exp_ret   = er;
        v.exp_found = ef;
        return v;
    endfunction

    // LOAD cycles needed to see len valid beats under the pattern
    function automatic int load_cycles(input int len, input logic [7:0] pat);
        int ones = 0;
        int k = 0;
        while (ones < len && k < 1000) begin
            if (pat[k % 8]) ones++;
            k++;
        end
        return k;
    endfunction

    // Cycle numbering: the ap_start cycle is 1; done expected in cycle 1 + load + 2*len + 1
    task automatic run(input int id, input vec_t v);
        int cyc, done_cyc, acc, k, len, lc;
        len = (v.n_len > 7'd64) ? 64 : int'(v.n_len);
        lc  = load_cycles(len, v.pat);
        @(negedge ap_clk);
        ap_start = 1'b1;
        n_len    = v.n_len;
        in_valid = 1'b1;
        in_data  = JUNK;
        cyc = 1; done_cyc = 0; acc = 0; k = 0;
        while (done_cyc == 0 && cyc < 400) begin
            @(negedge ap_clk);
            cyc++;
            ap_start = 1'b0;
            if (ap_done) begin
                done_cyc = cyc;
            end else if (in_ready) begin
                in_valid = v.pat[k % 8];
                in_data  = v.words[acc % 8];
                if (v.pat[k % 8]) acc++;
                k++;
            end else begin
                in_valid = 1'b1;
                in_data  = JUNK;
            end
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d done_seen", id), 32'(done_cyc != 0), 32'd1);
        chk($sformatf("v%0d latency", id), 32'(done_cyc), 32'(2 + lc + 2 * len));
        chk($sformatf("v%0d ready_with_done", id), 32'(ap_ready), 32'd1);
        chk($sformatf("v%0d ret", id), ap_return, v.exp_ret);
        chk($sformatf("v%0d found", id), 32'(found), 32'(v.exp_found));
        chk($sformatf("v%0d accepted", id), 32'(acc), 32'(len));
        @(negedge ap_clk);
        chk($sformatf("v%0d done_pulse", id), 32'(ap_done | ap_ready), 32'd0);
        chk($sformatf("v%0d idle_after", id), 32'(ap_idle), 32'd1);
        chk($sformatf("v%0d ret_held", id), ap_return, v.exp_ret);
    endtask

    initial begin
        vecs[0] = mk(7'd5, 8'hFF, 3, 3, 4, 3, 7, 0, 0, 0, 32'd3, 1'b1);
        vecs[1] = mk(7'd4, 8'hFF, 2, 2, 5, 5, 0, 0, 0, 0, NM, 1'b0);
        vecs[2] = mk(7'd0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, NM, 1'b0);
        vecs[3] = mk(7'd3, 8'hFF, 1, 2, 3, 0, 0, 0, 0, 0, NM, 1'b0);
        vecs[4] = mk(7'd6, 8'hFF, 5, 1, 5, 2, 5, 5, 0, 0, 32'd5, 1'b1);
        vecs[5] = mk(7'd7, 8'hFF, 0, NM, 1, NM, 2, NM, NM, 0, NM, 1'b1);
        vecs[6] = mk(7'd2, 8'hFF, 4, 5, 0, 0, 0, 0, 0, 0, NM, 1'b0);
        vecs[7] = mk(7'd3, 8'b0010_1001, 1, 1, 2, 0, 0, 0, 0, 0, 32'd1, 1'b1);
        vecs[8] = mk(7'd1, 8'hFF, 6, 0, 0, 0, 0, 0, 0, 0, 32'd6, 1'b1);
        vecs[9] = mk(7'd100, 8'hFF, 9, 9, 9, 9, 9, 9, 9, 9, 32'd9, 1'b1);
        v_after_rst = mk(7'd1, 8'hFF, 8, 0, 0, 0, 0, 0, 0, 0, 32'd8, 1'b1);

        ap_rst = 1'b1; ap_start = 1'b0; in_valid = 1'b1; in_data = JUNK; n_len = '0;
        repeat (2) @(negedge ap_clk);
        chk("rst idle", 32'(ap_idle), 32'd1);
        chk("rst done", 32'(ap_done), 32'd0);
        chk("rst ready", 32'(ap_ready), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst ret", ap_return, NM);
        chk("rst found", 32'(found), 32'd0);
        ap_rst = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < 10; i++) run(i, vecs[i]);

        // Reset while in VOTE: abort without a done pulse, then a fresh run
        @(negedge ap_clk);
        ap_start = 1'b1; n_len = 7'd5; in_valid = 1'b0;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            @(negedge ap_clk);
        end
        in_data = JUNK;
        @(negedge ap_clk);
        chk("vote busy", 32'(ap_idle), 32'd0);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("midrst ret", ap_return, NM);
        chk("midrst found", 32'(found), 32'd0);
        chk("midrst idle", 32'(ap_idle), 32'd1);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        ap_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            if (ap_done || ap_ready || in_ready || !ap_idle) bad++;
        end
        chk("midrst quiet", 32'(bad), 32'd0);
        in_valid = 1'b0;
        run(10, v_after_rst);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/find_majority_stream.md
Name: find_majority_stream

Overview:
- Parametrised successor to the single-function majority finder. Same ap_ctrl_hs block-level handshake as the rest of the codebase.
- Accepts a runtime-sized array of DATA_W-bit elements over a valid/ready input stream and buffers it internally.
- Runs a Boyer-Moore voting pass and then a verification pass.
- Returns the strict-majority element, or the NO_MAJ code if no element occurs in more than half of the positions.

Parameters:
- DATA_W, 32, element and return width in bits (>= 2).
- MAX_N, 64, buffer depth = maximum array length (>= 1).
- CNT_W, $clog2(MAX_N+1), width of all length and count registers.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  start request, sampled in IDLE only.
- ap_done  out  1  one-cycle pulse when the result is valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- n_len  in  CNT_W  array length, latched on the accepted ap_start.
- in_data  in  DATA_W  element stream data.
- in_valid  in  1  element stream valid.
- in_ready  out  1  high only in LOAD.
- ap_return  out  DATA_W  majority element, or NO_MAJ = all ones.
- found  out  1  1 = ap_return is a genuine majority.

Behaviour:
- Reset (ap_clk edge with ap_rst=1):
  - state=IDLE, ap_done=0, ap_ready=0, ap_idle=1, in_ready=0, ap_return=all ones, found=0.
  - All counters cleared; buffer contents don't-care.
  - Reset mid-operation aborts immediately: no done pulse, and stream words offered afterwards are not consumed until the next start.
- States: IDLE, LOAD, VOTE, VERIFY, DONE.
- IDLE:
  - ap_idle=1.
  - On ap_start=1, latch len = min(n_len, MAX_N).
  - If len==0, go to DONE with NO_MAJ/found=0.
  - Otherwise go to LOAD with idx=0.
  - ap_start outside IDLE is ignored.
- LOAD:
  - in_ready=1. Each cycle with in_valid=1 writes buf[idx]=in_data and increments idx.
  - When the len-th word is accepted, go to VOTE with idx=0, cand=0, cnt=0.
  - in_valid gaps stall LOAD without limit.
- VOTE, one element per cycle:
  - If cnt==0: cand=buf[idx], cnt=1.
  - Else if buf[idx]==cand: cnt+1.
  - Else: cnt-1.
  - After idx=len-1, go to VERIFY with idx=0, hits=0.
- VERIFY, one element per cycle:
  - hits increments when buf[idx]==cand.
  - After idx=len-1, go to DONE.
- Majority rule:
  - found = (2*hits > len), computed at CNT_W+1 bits so there is no overflow.
  - Ties (exactly len/2) are not a majority.
- DONE, one cycle:
  - ap_done=1 and ap_ready=1.
  - ap_return = cand if found, else all ones; found updated.
  - Then return to IDLE.
- Output hold: ap_return and found hold their value until the next DONE.
- Latency: from accepted ap_start to ap_done = 1 (IDLE->LOAD) + load cycles (>= len) + len + len + 1. For len=0 the latency is 1 cycle.
- Buffer reads are combinational-address/registered-free (distributed RAM); a single-port buffer is sufficient because the passes never overlap.
- A genuine majority equal to all ones is reported with found=1; downstream logic must use found, not the value alone.
- Back-to-back operation: ap_start held high in the cycle after DONE launches a new run from IDLE (one IDLE cycle minimum).

Test Plan:
- len=5, stream {3,3,4,3,7}, no in_valid gaps -> ap_done 17 cycles after start; ap_return=3, found=1; exactly one ap_done/ap_ready pulse.
- len=4, stream {2,2,5,5} -> ap_return=0xFFFFFFFF, found=0 (tie is not a majority).
- len=0 -> ap_done on the next cycle; ap_return=0xFFFFFFFF, found=0; in_ready never asserted.
- n_len=100 with MAX_N=64 -> exactly 64 words accepted and in_ready drops afterwards; with all words = 9, result is ap_return=9, found=1.
- len=3 {1,1,2} with in_valid toggling 1,0,0,1,0,1 -> result 1, found=1; done delayed exactly by the 3 stall cycles.
- ap_rst asserted during VOTE -> outputs return to reset values the next cycle, no ap_done; a subsequent run with {8} returns 8, found=1.
